// File: rtl/scct_compare.sv
// -----------------------------------------------------------------------------
// scct_compare
//
// Output-compare channel that sits downstream of the SCCT counter. It watches
// the counter value together with its one-cycle counter_changed strobe. When
// the armed compare value is reached, the channel:
//   - drives an action on the output pin,
//   - pulses match_o for one cycle, and
//   - raises a maskable, sticky interrupt flag.
// The channel runs either periodically or as a one-shot.
//
// The compare value is double-buffered. Host writes land in `compare`, while
// matching is done against `compare_shadow`. The shadow is reloaded on every
// arm and on every periodic hit.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   counter, counter_changed   counter value and its new-value strobe
//   compare_i / _wen           compare register write
//   mode_i / _wen              [1:0] pin action (0 none, 1 set, 2 clear,
//                              3 toggle), [2] one-shot
//   enable_i / _wen            1 arms (or re-arms), 0 disarms
//   irq_enable_i / _wen        interrupt mask write
//   irq_status_i / _wen        write 1 clears the sticky irq flag
//   compare_o, mode_o,
//   irq_enable_o               register readback
//   enable_o                   channel is ARMED or FIRED
//   irq_status_o               sticky interrupt flag
//   match_o                    one-cycle pulse, one cycle after each hit
//   oc_pin_o                   compare output pin
//   fsm_state                  current FSM state (IDLE/ARMED/FIRED), debug
//
// Write strobes follow a simple rule: a *_wen high for one clock commits the
// paired data on that rising edge. There is no back-pressure.
// -----------------------------------------------------------------------------
module scct_compare #(
    parameter int   CTR_WIDTH     = 32,
    parameter logic PIN_RESET_VAL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTR_WIDTH-1:0] counter,
    input  logic                 counter_changed,
    input  logic [CTR_WIDTH-1:0] compare_i,
    input  logic                 compare_i_wen,
    input  logic [2:0]           mode_i,
    input  logic                 mode_i_wen,
    input  logic                 enable_i,
    input  logic                 enable_i_wen,
    input  logic                 irq_enable_i,
    input  logic                 irq_enable_i_wen,
    input  logic                 irq_status_i,
    input  logic                 irq_status_i_wen,
    output logic [CTR_WIDTH-1:0] compare_o,
    output logic [2:0]           mode_o,
    output logic                 enable_o,
    output logic                 irq_enable_o,
    output logic                 irq_status_o,
    output logic                 match_o,
    output logic                 oc_pin_o,
    output logic [1:0]           fsm_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [1:0]           state;
    logic [CTR_WIDTH-1:0] compare;
    logic [CTR_WIDTH-1:0] compare_shadow;
    logic [2:0]           mode;
    logic                 irq_enable;
    logic                 irq_status;
    logic                 match;
    logic                 oc_pin;

    logic                 hit;
    logic                 disarm;
    logic                 hit_eff;
    logic [CTR_WIDTH-1:0] compare_next;
    logic                 pin_action;

    // A hit needs a fresh counter value. Equal values without the strobe
    // never match.
    assign hit     = (state == ST_ARMED) && counter_changed && (counter == compare_shadow);
    assign disarm  = enable_i_wen && !enable_i;
    // A disarm in the hit cycle suppresses every side effect of that hit.
    assign hit_eff = hit && !disarm;

    // A shadow reload in the same cycle as a compare write takes the new value.
    assign compare_next = compare_i_wen ? compare_i : compare;

    // The pin action always uses the mode value held before any same-cycle
    // mode write.
    always_comb begin
        pin_action = oc_pin;
        case (mode[1:0])
            2'd1:    pin_action = 1'b1;
            2'd2:    pin_action = 1'b0;
            2'd3:    pin_action = ~oc_pin;
            default: pin_action = oc_pin;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            compare        <= '0;
            compare_shadow <= '0;
            mode           <= 3'd0;
            irq_enable     <= 1'b0;
            irq_status     <= 1'b0;
            match          <= 1'b0;
            oc_pin         <= PIN_RESET_VAL;
        end else begin
            if (compare_i_wen)    compare    <= compare_i;
            if (mode_i_wen)       mode       <= mode_i;
            if (irq_enable_i_wen) irq_enable <= irq_enable_i;

            match <= hit_eff;

            // Setting the flag wins over a same-cycle clear.
            if (hit_eff && irq_enable)
                irq_status <= 1'b1;
            else if (irq_status_i_wen && irq_status_i)
                irq_status <= 1'b0;

            if (enable_i_wen) begin
                if (enable_i) begin
                    // Arm or re-arm. A hit in this cycle still drives the pin.
                    state          <= ST_ARMED;
                    compare_shadow <= compare_next;
                    if (hit_eff) oc_pin <= pin_action;
                end else begin
                    state  <= ST_IDLE;
                    oc_pin <= PIN_RESET_VAL;
                end
            end else if (hit_eff) begin
                oc_pin <= pin_action;
                if (mode[2])
                    state <= ST_FIRED;
                else
                    compare_shadow <= compare_next;
            end
        end
    end

    assign compare_o    = compare;
    assign mode_o       = mode;
    assign enable_o     = (state == ST_ARMED) || (state == ST_FIRED);
    assign irq_enable_o = irq_enable;
    assign irq_status_o = irq_status;
    assign match_o      = match;
    assign oc_pin_o     = oc_pin;
    assign fsm_state    = state;

endmodule

// File: tb/tb_scct_compare.sv
// -----------------------------------------------------------------------------
// tb_scct_compare
//
// Directed bench for scct_compare with an 8-bit counter. The bench drives the
// counter directly. Inputs are driven 1 ns after the rising edge, and outputs
// are sampled at the same point after the following edge.
// -----------------------------------------------------------------------------
module tb_scct_compare;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] counter;
  logic         counter_changed;
  logic [W-1:0] compare_i;
  logic         compare_i_wen;
  logic [2:0]   mode_i;
  logic         mode_i_wen;
  logic         enable_i;
  logic         enable_i_wen;
  logic         irq_enable_i;
  logic         irq_enable_i_wen;
  logic         irq_status_i;
  logic         irq_status_i_wen;
  logic [W-1:0] compare_o;
  logic [2:0]   mode_o;
  logic         enable_o;
  logic         irq_enable_o;
  logic         irq_status_o;
  logic         match_o;
  logic         oc_pin_o;
  logic [1:0]   fsm_state;

  int n_assert = 0;
  int n_fail   = 0;
  int mcount;

  scct_compare #(.CTR_WIDTH(W), .PIN_RESET_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .counter(counter), .counter_changed(counter_changed),
    .compare_i(compare_i), .compare_i_wen(compare_i_wen),
    .mode_i(mode_i), .mode_i_wen(mode_i_wen),
    .enable_i(enable_i), .enable_i_wen(enable_i_wen),
    .irq_enable_i(irq_enable_i), .irq_enable_i_wen(irq_enable_i_wen),
    .irq_status_i(irq_status_i), .irq_status_i_wen(irq_status_i_wen),
    .compare_o(compare_o), .mode_o(mode_o), .enable_o(enable_o),
    .irq_enable_o(irq_enable_o), .irq_status_o(irq_status_o),
    .match_o(match_o), .oc_pin_o(oc_pin_o), .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // One clock: commit the current inputs, then drop every one-cycle strobe.
  task automatic cyc();
    @(posedge clk);
    #1;
    compare_i_wen    = 1'b0;
    mode_i_wen       = 1'b0;
    enable_i_wen     = 1'b0;
    irq_enable_i_wen = 1'b0;
    irq_status_i_wen = 1'b0;
    counter_changed  = 1'b0;
  endtask

  // Present a new counter value for one cycle, with its strobe.
  task automatic show(input logic [W-1:0] v);
    counter         = v;
    counter_changed = 1'b1;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    counter = '0; counter_changed = 1'b0;
    compare_i = '0; compare_i_wen = 1'b0;
    mode_i = 3'd0; mode_i_wen = 1'b0;
    enable_i = 1'b0; enable_i_wen = 1'b0;
    irq_enable_i = 1'b0; irq_enable_i_wen = 1'b0;
    irq_status_i = 1'b0; irq_status_i_wen = 1'b0;
    repeat (3) cyc();
    chk("rst_match", match_o, 0);
    chk("rst_pin", oc_pin_o, 0);
    chk("rst_enable", enable_o, 0);
    chk("rst_irq", irq_status_o, 0);
    chk("rst_compare", compare_o, 0);
    rst = 1'b0;
    cyc();

    // 1: periodic toggle at compare=5, repeating every 256 counts
    compare_i = 8'd5; compare_i_wen = 1'b1;
    mode_i = 3'd3; mode_i_wen = 1'b1;
    cyc();
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    chk("t1_armed_state", fsm_state, 1);
    chk("t1_enable", enable_o, 1);
    mcount = 0;
    for (int i = 0; i < 5; i++) begin
      show(i[W-1:0]);
      mcount += int'(match_o);
    end
    chk("t1_no_early_match", mcount, 0);
    show(8'd5);
    chk("t1_match", match_o, 1);
    chk("t1_pin_toggle", oc_pin_o, 1);
    mcount = 0;
    for (int i = 6; i < 261; i++) begin
      show(i[W-1:0]);
      mcount += int'(match_o);
    end
    chk("t1_no_match_wrap", mcount, 0);
    show(8'd5);
    chk("t1_match_again", match_o, 1);
    chk("t1_pin_toggle_back", oc_pin_o, 0);
    chk("t1_irq_masked", irq_status_o, 0);

    // 2: one-shot set at compare=3, irq enabled
    enable_i = 1'b0; enable_i_wen = 1'b1;
    cyc();
    chk("t2_disarmed", enable_o, 0);
    mode_i = 3'd5; mode_i_wen = 1'b1;
    compare_i = 8'd3; compare_i_wen = 1'b1;
    irq_enable_i = 1'b1; irq_enable_i_wen = 1'b1;
    cyc();
    chk("t2_mode_rb", mode_o, 5);
    chk("t2_irqen_rb", irq_enable_o, 1);
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    mcount = 0;
    for (int i = 0; i < 3; i++) begin
      show(i[W-1:0]);
      mcount += int'(match_o);
    end
    show(8'd3);
    chk("t2_match", match_o, 1);
    chk("t2_pin_set", oc_pin_o, 1);
    chk("t2_irq", irq_status_o, 1);
    chk("t2_fired", fsm_state, 2);
    chk("t2_enable_fired", enable_o, 1);
    for (int i = 4; i < 260; i++) begin
      show(i[W-1:0]);
      mcount += int'(match_o);
    end
    chk("t2_no_match_fired", mcount, 0);
    chk("t2_pin_hold", oc_pin_o, 1);
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    chk("t2_rearmed", fsm_state, 1);
    counter = 8'd3; counter_changed = 1'b0;
    cyc();
    chk("t2_no_strobe_no_match", match_o, 0);
    show(8'd3);
    chk("t2_rearm_match", match_o, 1);

    // 3: irq clear in the hit cycle loses to the set
    irq_status_i = 1'b1; irq_status_i_wen = 1'b1;
    cyc();
    chk("t3_irq_cleared", irq_status_o, 0);
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    irq_status_i = 1'b1; irq_status_i_wen = 1'b1;
    show(8'd3);
    chk("t3_match", match_o, 1);
    chk("t3_set_wins", irq_status_o, 1);
    irq_status_i = 1'b1; irq_status_i_wen = 1'b1;
    cyc();
    chk("t3_clear_later", irq_status_o, 0);

    // 4: counter holds 7 for four cycles (prescaled): exactly one match
    mode_i = 3'd3; mode_i_wen = 1'b1;
    compare_i = 8'd7; compare_i_wen = 1'b1;
    cyc();
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    show(8'd7);
    chk("t4_match", match_o, 1);
    chk("t4_pin_toggle", oc_pin_o, 0);
    mcount = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      mcount += int'(match_o);
    end
    chk("t4_single_pulse", mcount, 0);

    // 5: compare write in the hit cycle reloads the next target
    compare_i = 8'd4; compare_i_wen = 1'b1;
    cyc();
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    compare_i = 8'd9; compare_i_wen = 1'b1;
    show(8'd4);
    chk("t5_match_old", match_o, 1);
    chk("t5_pin", oc_pin_o, 1);
    chk("t5_compare_rb", compare_o, 9);
    show(8'd4);
    chk("t5_no_match_old", match_o, 0);
    show(8'd9);
    chk("t5_match_new", match_o, 1);
    chk("t5_pin_back", oc_pin_o, 0);

    // 6: disarm in the hit cycle wins over the hit
    mode_i = 3'd1; mode_i_wen = 1'b1;
    compare_i = 8'd20; compare_i_wen = 1'b1;
    cyc();
    irq_status_i = 1'b1; irq_status_i_wen = 1'b1;
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    show(8'd20);
    chk("t6_pre_match", match_o, 1);
    chk("t6_pre_pin", oc_pin_o, 1);
    irq_status_i = 1'b1; irq_status_i_wen = 1'b1;
    cyc();
    chk("t6_irq_clr", irq_status_o, 0);
    enable_i = 1'b0; enable_i_wen = 1'b1;
    show(8'd20);
    chk("t6_no_match", match_o, 0);
    chk("t6_no_irq", irq_status_o, 0);
    chk("t6_pin_reset", oc_pin_o, 0);
    chk("t6_enable_off", enable_o, 0);
    chk("t6_idle", fsm_state, 0);

    // reset in the middle of operation overrides a hit and writes
    enable_i = 1'b1; enable_i_wen = 1'b1;
    cyc();
    rst = 1'b1;
    compare_i = 8'd77; compare_i_wen = 1'b1;
    show(8'd20);
    rst = 1'b0;
    chk("rst_mid_match", match_o, 0);
    chk("rst_mid_compare", compare_o, 0);
    chk("rst_mid_enable", enable_o, 0);
    chk("rst_mid_mode", mode_o, 0);
    chk("rst_mid_irqen", irq_enable_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
